// File: rtl/sllv0.sv
// Single-cycle MIPS-subset core with integrated 64-word ROM and 64-word data RAM.
// One instruction retires per clock; no stalls or backpressure, memory write port exported.
module sllv0 (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] writedata,
  output logic [31:0] dataadr,
  output logic        memwrite
);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLLV = 3'd5;
  localparam logic [2:0] ALU_SLL  = 3'd6;

  logic [31:0] pc, pcnext, pcplus4, instr, signimm;
  logic [31:0] rf [0:31];
  logic [31:0] dmem [0:63];
  logic [31:0] rd1, rd2, srcb, aluresult, wd;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, wa;
  logic [2:0]  aluop;
  logic        regwrite, regdst, alusrc, memtoreg, branch, jump;

  function automatic logic [31:0] rom(input logic [5:0] idx);
    case (idx)
      6'd0:    rom = 32'h20020004;
      6'd1:    rom = 32'h20030002;
      6'd2:    rom = 32'h00622004;
      6'd3:    rom = 32'hAC04000C;
      default: rom = 32'h00000000;
    endcase
  endfunction

  assign instr   = rom(pc[7:2]);
  assign op      = instr[31:26];
  assign rs      = instr[25:21];
  assign rt      = instr[20:16];
  assign rd      = instr[15:11];
  assign shamt   = instr[10:6];
  assign funct   = instr[5:0];
  assign signimm = {{16{instr[15]}}, instr[15:0]};

  always_comb begin
    regwrite = 1'b0;
    regdst   = 1'b0;
    alusrc   = 1'b0;
    memtoreg = 1'b0;
    memwrite = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    aluop    = ALU_ADD;
    case (op)
      6'h00: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        case (funct)
          6'h20:   aluop = ALU_ADD;
          6'h22:   aluop = ALU_SUB;
          6'h24:   aluop = ALU_AND;
          6'h25:   aluop = ALU_OR;
          6'h2A:   aluop = ALU_SLT;
          6'h04:   aluop = ALU_SLLV;
          6'h00:   aluop = ALU_SLL;
          default: regwrite = 1'b0;
        endcase
      end
      6'h08: begin regwrite = 1'b1; alusrc = 1'b1; end
      6'h23: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; end
      6'h2B: begin alusrc = 1'b1; memwrite = 1'b1; end
      6'h04: begin branch = 1'b1; aluop = ALU_SUB; end
      6'h02: jump = 1'b1;
      default: ;
    endcase
  end

  assign rd1  = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd2  = (rt == 5'd0) ? 32'd0 : rf[rt];
  assign srcb = alusrc ? signimm : rd2;

  // Shifts operate on rt (rd2); sllv takes only the low 5 bits of rs.
  always_comb begin
    aluresult = 32'd0;
    case (aluop)
      ALU_ADD:  aluresult = rd1 + srcb;
      ALU_SUB:  aluresult = rd1 - srcb;
      ALU_AND:  aluresult = rd1 & srcb;
      ALU_OR:   aluresult = rd1 | srcb;
      ALU_SLT:  aluresult = {31'd0, $signed(rd1) < $signed(srcb)};
      ALU_SLLV: aluresult = rd2 << rd1[4:0];
      ALU_SLL:  aluresult = rd2 << shamt;
      default:  aluresult = 32'd0;
    endcase
  end

  assign dataadr   = aluresult;
  assign writedata = rd2;
  assign wa        = regdst ? rd : rt;
  assign wd        = memtoreg ? dmem[aluresult[7:2]] : aluresult;
  assign pcplus4   = pc + 32'd4;

  always_comb begin
    pcnext = pcplus4;
    if (jump)
      pcnext = {pcplus4[31:28], instr[25:0], 2'b00};
    else if (branch && (aluresult == 32'd0))
      pcnext = pcplus4 + {signimm[29:0], 2'b00};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 32'd0;
    end else begin
      pc <= pcnext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (regwrite && (wa != 5'd0)) begin
      rf[wa] <= wd;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else if (memwrite) begin
      dmem[aluresult[7:2]] <= writedata;
    end
  end

endmodule

// File: tb/tb_sllv0.sv
// Scoreboarded bench for sllv0: expected sw transactions are queued, popped when memwrite is seen.
module tb_sllv0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] writedata, dataadr;
  logic        memwrite;
  logic [31:0] fi;

  int asserts = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } sw_t;
  sw_t expq[$];

  always #5 clk = ~clk;

  sllv0 dut (
    .clk(clk),
    .reset(reset),
    .writedata(writedata),
    .dataadr(dataadr),
    .memwrite(memwrite)
  );

  // Leaves the bench at the first negedge with reset high (PC=0), 1ns after it.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    asserts++;
    if (memwrite !== 1'b0) begin failures++; $display("FAIL reset_memwrite: got %b expected 0", memwrite); end
    asserts++;
    if (dataadr !== 32'd4) begin failures++; $display("FAIL reset_dataadr: got %h expected 00000004", dataadr); end
    asserts++;
    if (writedata !== 32'd0) begin failures++; $display("FAIL reset_writedata: got %h expected 00000000", writedata); end
    asserts++;
    if (dut.pc !== 32'd0) begin failures++; $display("FAIL reset_pc: got %h expected 00000000", dut.pc); end
  endtask

  task automatic test_program();
    sw_t got, exp;
    do_reset();
    expq.push_back('{adr: 32'd12, dat: 32'd16});
    for (int cyc = 0; cyc < 15; cyc++) begin
      asserts++;
      if (memwrite !== (cyc == 3)) begin
        failures++;
        $display("FAIL prog_memwrite cyc%0d: got %b expected %b", cyc, memwrite, (cyc == 3));
      end
      if (memwrite === 1'b1 && expq.size() > 0) begin
        exp = expq.pop_front();
        got = '{adr: dataadr, dat: writedata};
        asserts++;
        if (got !== exp) begin failures++; $display("FAIL prog_sw: got adr %h dat %h expected adr %h dat %h", got.adr, got.dat, exp.adr, exp.dat); end
      end
      if (cyc == 3) begin
        asserts++;
        if (dut.rf[2] !== 32'd4) begin failures++; $display("FAIL prog_r2: got %h expected 00000004", dut.rf[2]); end
        asserts++;
        if (dut.rf[3] !== 32'd2) begin failures++; $display("FAIL prog_r3: got %h expected 00000002", dut.rf[3]); end
        asserts++;
        if (dut.rf[4] !== 32'd16) begin failures++; $display("FAIL prog_r4: got %h expected 00000010", dut.rf[4]); end
      end
      if (cyc == 4) begin
        asserts++;
        if (dut.dmem[3] !== 32'd16) begin failures++; $display("FAIL prog_mem3: got %h expected 00000010", dut.dmem[3]); end
      end
      @(negedge clk);
      #1;
    end
    asserts++;
    if (expq.size() != 0) begin failures++; $display("FAIL prog_sw_missing: got %0d pending expected 0", expq.size()); expq.delete(); end
    asserts++;
    if (dut.rf[0] !== 32'd0) begin failures++; $display("FAIL prog_r0: got %h expected 00000000", dut.rf[0]); end
    asserts++;
    if (dut.dmem[0] !== 32'd0) begin failures++; $display("FAIL prog_mem0: got %h expected 00000000", dut.dmem[0]); end
  endtask

  task automatic test_mid_reset();
    sw_t got, exp;
    // State still holds Mem[3]=16 and $4=16 from the previous run.
    reset = 1'b0;
    #1;
    asserts++;
    if (dut.dmem[3] !== 32'd0) begin failures++; $display("FAIL mid_mem3_clear: got %h expected 00000000", dut.dmem[3]); end
    asserts++;
    if (dut.rf[4] !== 32'd0) begin failures++; $display("FAIL mid_r4_clear: got %h expected 00000000", dut.rf[4]); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    @(negedge clk);
    @(negedge clk);
    #1;
    asserts++;
    if (dut.rf[2] !== 32'd4) begin failures++; $display("FAIL mid_r2_before: got %h expected 00000004", dut.rf[2]); end
    reset = 1'b0;
    #1;
    asserts++;
    if (dut.rf[2] !== 32'd0) begin failures++; $display("FAIL mid_r2_clear: got %h expected 00000000", dut.rf[2]); end
    asserts++;
    if (dut.pc !== 32'd0) begin failures++; $display("FAIL mid_pc: got %h expected 00000000", dut.pc); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    expq.push_back('{adr: 32'd12, dat: 32'd16});
    for (int cyc = 0; cyc < 7; cyc++) begin
      asserts++;
      if (memwrite !== (cyc == 3)) begin
        failures++;
        $display("FAIL mid_memwrite cyc%0d: got %b expected %b", cyc, memwrite, (cyc == 3));
      end
      if (memwrite === 1'b1 && expq.size() > 0) begin
        exp = expq.pop_front();
        got = '{adr: dataadr, dat: writedata};
        asserts++;
        if (got !== exp) begin failures++; $display("FAIL mid_sw: got adr %h dat %h expected adr %h dat %h", got.adr, got.dat, exp.adr, exp.dat); end
      end
      @(negedge clk);
      #1;
    end
    asserts++;
    if (expq.size() != 0) begin failures++; $display("FAIL mid_sw_missing: got %0d pending expected 0", expq.size()); expq.delete(); end
  endtask

  task automatic test_wrap();
    sw_t got, exp;
    do_reset();
    expq.push_back('{adr: 32'd12, dat: 32'd16});
    expq.push_back('{adr: 32'd12, dat: 32'd16});
    for (int cyc = 0; cyc < 70; cyc++) begin
      if (memwrite !== (cyc == 3 || cyc == 67)) begin
        asserts++;
        failures++;
        $display("FAIL wrap_memwrite cyc%0d: got %b expected %b", cyc, memwrite, (cyc == 3 || cyc == 67));
      end else if (cyc == 3 || cyc == 67) begin
        asserts++;
      end
      if (memwrite === 1'b1 && expq.size() > 0) begin
        exp = expq.pop_front();
        got = '{adr: dataadr, dat: writedata};
        asserts++;
        if (got !== exp) begin failures++; $display("FAIL wrap_sw cyc%0d: got adr %h dat %h expected adr %h dat %h", cyc, got.adr, got.dat, exp.adr, exp.dat); end
      end
      @(negedge clk);
      #1;
    end
    asserts++;
    if (expq.size() != 0) begin failures++; $display("FAIL wrap_sw_missing: got %0d pending expected 0", expq.size()); expq.delete(); end
  endtask

  task automatic test_sllv_variant();
    sw_t got, exp;
    do_reset();
    fi = 32'h20050025;             // addi $5,$0,0x25
    force dut.instr = fi;
    @(negedge clk);
    fi = 32'h20060001;             // addi $6,$0,1
    @(negedge clk);
    fi = 32'h00A63804;             // sllv $7,$6,$5
    @(negedge clk);
    fi = 32'hAC070000;             // sw $7,0($0)
    expq.push_back('{adr: 32'd0, dat: 32'h00000020});
    #1;
    asserts++;
    if (memwrite !== 1'b1) begin failures++; $display("FAIL sllv5_memwrite: got %b expected 1", memwrite); end
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      got = '{adr: dataadr, dat: writedata};
      asserts++;
      if (got !== exp) begin failures++; $display("FAIL sllv5_sw: got adr %h dat %h expected adr %h dat %h", got.adr, got.dat, exp.adr, exp.dat); end
    end
    @(negedge clk);
    fi = 32'h000637C0;             // sll $6,$6,31
    @(negedge clk);
    fi = 32'hAC060000;             // sw $6,0($0)
    expq.push_back('{adr: 32'd0, dat: 32'h80000000});
    #1;
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      got = '{adr: dataadr, dat: writedata};
      asserts++;
      if (got !== exp) begin failures++; $display("FAIL sll31_sw: got adr %h dat %h expected adr %h dat %h", got.adr, got.dat, exp.adr, exp.dat); end
    end
    @(negedge clk);
    fi = 32'h20050001;             // addi $5,$0,1
    @(negedge clk);
    fi = 32'h00A63804;             // sllv $7,$6,$5
    @(negedge clk);
    fi = 32'hAC070000;             // sw $7,0($0)
    expq.push_back('{adr: 32'd0, dat: 32'h00000000});
    #1;
    if (expq.size() > 0) begin
      exp = expq.pop_front();
      got = '{adr: dataadr, dat: writedata};
      asserts++;
      if (got !== exp) begin failures++; $display("FAIL sllv_lost_sw: got adr %h dat %h expected adr %h dat %h", got.adr, got.dat, exp.adr, exp.dat); end
    end
    @(negedge clk);
    release dut.instr;
    do_reset();
  endtask

  initial begin
    fi = 32'd0;
    test_reset();
    test_program();
    test_mid_reset();
    test_wrap();
    test_sllv_variant();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/sllv0.md
# sllv0

Single-cycle 32-bit MIPS-subset processor with its program and data memories integrated. It serves as a self-contained top for verifying the `sllv` (shift left logical variable) instruction path. Each clock edge retires one instruction. The data-memory write port is exported for observation.

## Interface
- No parameters. Instruction and data memories are fixed at 64 words each.
- `clk` input 1: system clock. All state updates occur on the rising edge.
- `reset` input 1: asynchronous reset, active-low.
  - When low, PC, register file and data memory are cleared.
  - Released synchronously with respect to the next rising edge.
- `writedata` output 32: data-memory write data, equal to the register file value of `rt`.
- `dataadr` output 32: data-memory byte address, equal to the ALU result.
- `memwrite` output 1: high while the current instruction is `sw`.

## Operation
- PC, 32 bits:
  - Reset value 0.
  - Normal update: PC+4 each cycle.
  - `beq` taken: PC+4+(signext(imm)<<2).
  - `j`: {PC+4[31:28], target, 2'b00}.
- Instruction memory is combinational ROM read at pc[7:2]. Preloaded program:
  - word 0: 0x20020004, `addi $2,$0,4`
  - word 1: 0x20030002, `addi $3,$0,2`
  - word 2: 0x00622004, `sllv $4,$2,$3`
  - word 3: 0xAC04000C, `sw $4,12($0)`
  - words 4–63: 0x00000000, executed as a no-op (writes to $0 are discarded).
- Register file:
  - 32×32 bits, two combinational read ports, one write port written on the rising edge.
  - $0 always reads 0.
  - All registers clear on reset.
- Decoded instructions:
  - R-type (op 0), by funct:
    - `add` 0x20, `sub` 0x22, `and` 0x24, `or` 0x25, `slt` 0x2A.
    - `sllv` 0x04: rd = rt << rs[4:0]. Only the low 5 bits of rs are used. Zero fill. Bits shifted past bit 31 are lost.
    - `sll` 0x00: rd = rt << shamt.
  - I-type: `addi` 0x08 (sign-extended immediate), `lw` 0x23, `sw` 0x2B, `beq` 0x04.
  - J-type: `j` 0x02.
  - Unknown opcodes and functs: no register write, no memory write, PC+4.
- Arithmetic:
  - 32-bit two's complement.
  - Overflow ignored; no exceptions.
  - `slt` is a signed compare that yields 0 or 1.
- Data memory:
  - 64×32 bits, word index dataadr[7:2].
  - Written on the rising edge when `memwrite`=1.
  - Combinational read for `lw`.
  - Address bits [1:0] ignored.
- `dataadr`, `writedata` and `memwrite` are combinational from the current PC and state.

## Timing
- While `reset` is low:
  - PC = 0, so the outputs reflect word 0 (`addi`).
  - `memwrite`=0, `dataadr`=4, `writedata`=0.
- Latency is one cycle per instruction. The result of instruction N is visible to instruction N+1 with no hazards (single-cycle).
- Program trace after reset release (edges numbered from the first rising edge with `reset` high):
  - Cycle 0 (PC=0): $2←4 at the end of the cycle.
  - Cycle 1 (PC=4): $3←2.
  - Cycle 2 (PC=8): $4←16.
  - Cycle 3 (PC=12): `memwrite`=1, `dataadr`=12, `writedata`=16. Mem[3]←16 on the closing edge.
  - Cycle 4 onward: `memwrite`=0.
  - PC increments through the zero region, then wraps through the ROM by index aliasing: pc[7:2] wraps at 64 words.
- Asserting `reset` mid-program immediately restarts at PC 0 with cleared registers and memory.
- Simultaneous register write and read of the same register within a cycle returns the old value. The new value appears the next cycle.

## Test plan
- Hold `reset` low for 2 cycles, then high -> at the first negedge with `memwrite`=1, `dataadr`=12 and `writedata`=16. No earlier `memwrite` pulse occurs.
- During reset -> `memwrite`=0, `dataadr`=4, `writedata`=0.
- Reset released, run 3 cycles -> internal $2=4, $3=2, $4=16. The next edge writes Mem[3]=16.
- Reassert `reset` at cycle 2, release -> the sequence restarts and the `sw` occurs exactly 4 cycles after the release.
- Variant ROM test `sllv` with rs=0x25 and rt=1 -> the shift uses 5 bits (amount 5), result 0x20. With rt=0x80000000 and rs=1 -> result 0.
- Run 10 cycles past the `sw` -> `memwrite` remains 0. The zero instructions do not modify $0 or memory.
